// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the serial add/subtract unit:
//   state_t   - control FSM states (IDLE / RUN / DONE)
//   nch       - number of STEP-bit chunks in a WIDTH-bit operand
//   cnt_width - chunk counter width, clog2(NCH) with a floor of 1
//   cfg_ok    - configuration legality check (STEP divides WIDTH)
// -----------------------------------------------------------------------------
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int nch(input int width, input int step);
      return width / step;
   endfunction

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic bit cfg_ok(input int width, input int step);
      return (width >= 2) && (step >= 1) && (step <= width) && ((width % step) == 0);
   endfunction

endpackage

// File: rtl/fa_cell.sv
// -----------------------------------------------------------------------------
// fa_cell
// One-bit combinational full adder.
// Ports:
//   A, B, Cin : addend bits and carry in
//   SO        : sum bit
//   Cout      : carry out
// -----------------------------------------------------------------------------
module fa_cell (
   input  logic A,
   input  logic B,
   input  logic Cin,
   output logic SO,
   output logic Cout
);

   assign SO   = A ^ B ^ Cin;
   assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder_n.sv
// -----------------------------------------------------------------------------
// serial_adder_n
// Multi-cycle WIDTH-bit add/subtract unit. Operands are consumed STEP bits per
// clock through a ripple chain of STEP fa_cell instances; the carry is held in
// a register between chunks. start/done handshake for a sequencing controller.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   start : request, honoured in IDLE or DONE
//   sub   : 0 = A+B+Cin, 1 = A-B (latched on accepted start)
//   A, B  : WIDTH-bit operands (latched on accepted start)
//   Cin   : carry in for add, ignored for subtract (latched on accepted start)
//   SO    : result, stable from done until the next accepted start
//   Cout  : carry out of the MSB (subtract: 1 = no borrow)
//   OV    : signed overflow (carry into MSB xor carry out of MSB)
//   busy  : high while chunks are being processed
//   done  : one-cycle pulse when SO/Cout/OV are valid
// -----------------------------------------------------------------------------
module serial_adder_n
   import adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int STEP  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic [WIDTH-1:0] SO,
   output logic             Cout,
   output logic             OV,
   output logic             busy,
   output logic             done
);

   localparam int NCH   = nch(WIDTH, STEP);
   localparam int CNT_W = cnt_width(NCH);

   generate
      if (!cfg_ok(WIDTH, STEP)) begin : g_bad_cfg
         $error("serial_adder_n: STEP must divide WIDTH and WIDTH must be >= 2");
      end
   endgenerate

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] cnt_q;
   logic             carry_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;

   logic [STEP-1:0]  a_chunk;
   logic [STEP-1:0]  b_chunk;
   logic [STEP-1:0]  sum_chunk;
   logic [STEP:0]    carry;
   logic             last_chunk;
   logic             accept;
   int               base;

   // A new request is taken in IDLE and also in DONE, so back-to-back
   // operations need no idle cycle in between.
   assign accept     = start && ((state_q == IDLE) || (state_q == DONE));
   assign last_chunk = (cnt_q == CNT_W'(NCH - 1));
   assign base       = int'(cnt_q) * STEP;

   assign a_chunk = a_q[base +: STEP];
   assign b_chunk = b_q[base +: STEP];

   // Ripple chain for the current chunk, seeded by the inter-chunk carry.
   assign carry[0] = carry_q;

   genvar gi;
   generate
      for (gi = 0; gi < STEP; gi++) begin : g_fa
         fa_cell u_fa (
            .A    (a_chunk[gi]),
            .B    (b_chunk[gi]),
            .Cin  (carry[gi]),
            .SO   (sum_chunk[gi]),
            .Cout (carry[gi+1])
         );
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) state_d = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last_chunk) state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = start ? RUN : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         SO      <= '0;
         Cout    <= 1'b0;
         OV      <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            cnt_q   <= '0;
            carry_q <= sub ? 1'b1 : Cin;
            SO      <= '0;
            Cout    <= 1'b0;
            OV      <= 1'b0;
         end else if (state_q == RUN) begin
            SO[base +: STEP] <= sum_chunk;
            carry_q          <= carry[STEP];
            cnt_q            <= last_chunk ? '0 : cnt_q + 1'b1;
            // Flags come only from the MSB chunk: carry[STEP-1] is the
            // carry into bit WIDTH-1, carry[STEP] the carry out of it.
            if (last_chunk) begin
               Cout <= carry[STEP];
               OV   <= carry[STEP] ^ carry[STEP-1];
            end
         end
      end
   end

   // Operand latches carry no reset; they are only read after an accept.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_q <= A;
         b_q <= sub ? ~B : B;
      end
   end

endmodule

// File: tb/tb_serial_adder_n.sv
module tb_serial_adder_n;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       sub_i;
   logic [7:0] a_i;
   logic [7:0] b_i;
   logic       cin_i;
   logic [3:0] start_v;

   logic [7:0] so_w   [4];
   logic       cout_w [4];
   logic       ov_w   [4];
   logic       busy_w [4];
   logic       done_w [4];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // dut0: STEP=1, dut1: STEP=2, dut2: STEP=4, dut3: STEP=8
   serial_adder_n #(.WIDTH(8), .STEP(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sub(sub_i), .A(a_i), .B(b_i),
      .Cin(cin_i), .SO(so_w[0]), .Cout(cout_w[0]), .OV(ov_w[0]), .busy(busy_w[0]), .done(done_w[0]));
   serial_adder_n #(.WIDTH(8), .STEP(2)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sub(sub_i), .A(a_i), .B(b_i),
      .Cin(cin_i), .SO(so_w[1]), .Cout(cout_w[1]), .OV(ov_w[1]), .busy(busy_w[1]), .done(done_w[1]));
   serial_adder_n #(.WIDTH(8), .STEP(4)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start_v[2]), .sub(sub_i), .A(a_i), .B(b_i),
      .Cin(cin_i), .SO(so_w[2]), .Cout(cout_w[2]), .OV(ov_w[2]), .busy(busy_w[2]), .done(done_w[2]));
   serial_adder_n #(.WIDTH(8), .STEP(8)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start_v[3]), .sub(sub_i), .A(a_i), .B(b_i),
      .Cin(cin_i), .SO(so_w[3]), .Cout(cout_w[3]), .OV(ov_w[3]), .busy(busy_w[3]), .done(done_w[3]));

   task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present operands and start at a negedge, confirm acceptance at the edge,
   // then scramble the inputs so a missing operand latch shows up.
   task automatic accept_op(input int sel, input logic [7:0] a, input logic [7:0] b,
                            input logic cin, input logic sb, input string tag);
      @(negedge clk);
      a_i = a; b_i = b; cin_i = cin; sub_i = sb;
      start_v[sel] = 1'b1;
      @(posedge clk); #1;
      chk(32'(busy_w[sel]), 32'd1, {tag, "_busy"});
      start_v[sel] = 1'b0;
      a_i = ~a; b_i = ~b; cin_i = ~cin; sub_i = ~sb;
   endtask

   // Count edges after acceptance until done is visible (bounded), then check
   // latency and results. Returns with done still high (DONE cycle).
   task automatic wait_done(input int sel, input int nch, input logic [7:0] eso,
                            input logic ecout, input logic eov, input string tag);
      int n;
      n = 0;
      while (n < 40) begin
         @(posedge clk); #1;
         n++;
         if (done_w[sel] === 1'b1) break;
      end
      chk(32'(n), 32'(nch), {tag, "_latency"});
      chk(32'(busy_w[sel]), 32'd0, {tag, "_busy_at_done"});
      chk(32'(so_w[sel]), 32'(eso), {tag, "_SO"});
      chk(32'(cout_w[sel]), 32'(ecout), {tag, "_Cout"});
      chk(32'(ov_w[sel]), 32'(eov), {tag, "_OV"});
   endtask

   initial begin
      int ndone;
      logic [7:0] so_at_done;

      rst_n = 1'b0; start_v = '0; a_i = '0; b_i = '0; cin_i = 1'b0; sub_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         chk(32'(so_w[i]),   32'd0, "reset_SO");
         chk(32'(cout_w[i]), 32'd0, "reset_Cout");
         chk(32'(ov_w[i]),   32'd0, "reset_OV");
         chk(32'(busy_w[i]), 32'd0, "reset_busy");
         chk(32'(done_w[i]), 32'd0, "reset_done");
      end
      @(negedge clk); rst_n = 1'b1;

      // STEP=1: 0xFF + 0x01 wraps to 0 with carry, no signed overflow
      accept_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, "t1");
      wait_done(0, 8, 8'h00, 1'b1, 1'b0, "t1");
      @(posedge clk); #1;
      chk(32'(done_w[0]), 32'd0, "t1_done_one_cycle");

      // STEP=1: 0x7F + 0x01 = 0x80, positive overflow
      accept_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, "t2");
      wait_done(0, 8, 8'h80, 1'b0, 1'b1, "t2");

      // STEP=4: 5 - 7 = 0xFE, borrow (Cout=0), no overflow
      accept_op(2, 8'h05, 8'h07, 1'b1, 1'b1, "t3");
      wait_done(2, 2, 8'hFE, 1'b0, 1'b0, "t3");

      // STEP=8: single-chunk compute, 0x3C + 0x0F + 1 = 0x4C
      accept_op(3, 8'h3C, 8'h0F, 1'b1, 1'b0, "t3b");
      wait_done(3, 1, 8'h4C, 1'b0, 1'b0, "t3b");

      // STEP=2: 0x12 + 0x34 + 1 = 0x47; a start during RUN must be ignored
      accept_op(1, 8'h12, 8'h34, 1'b1, 1'b0, "t4");
      @(negedge clk);
      a_i = 8'hAA; b_i = 8'h00; cin_i = 1'b0; sub_i = 1'b0; start_v[1] = 1'b1;
      @(posedge clk); #1;
      start_v[1] = 1'b0;
      ndone = 0; so_at_done = 8'h00;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (done_w[1] === 1'b1) begin
            ndone++;
            so_at_done = so_w[1];
         end
      end
      chk(32'(ndone), 32'd1, "t4_done_count");
      chk(32'(so_at_done), 32'h47, "t4_SO_at_done");
      chk(32'(so_w[1]), 32'h47, "t4_SO_held");
      chk(32'(cout_w[1]), 32'd0, "t4_Cout");

      // STEP=1: reset mid-RUN at counter=3 aborts the operation
      accept_op(0, 8'hFF, 8'h00, 1'b0, 1'b0, "t5");
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b0;
      @(posedge clk); #1;
      chk(32'(so_w[0]),   32'd0, "t5_rst_SO");
      chk(32'(cout_w[0]), 32'd0, "t5_rst_Cout");
      chk(32'(ov_w[0]),   32'd0, "t5_rst_OV");
      chk(32'(busy_w[0]), 32'd0, "t5_rst_busy");
      chk(32'(done_w[0]), 32'd0, "t5_rst_done");
      @(negedge clk); rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (done_w[0] === 1'b1) ndone++;
      end
      chk(32'(ndone), 32'd0, "t5_no_done_after_abort");
      accept_op(0, 8'h80, 8'h80, 1'b0, 1'b0, "t5b");
      wait_done(0, 8, 8'h00, 1'b1, 1'b1, "t5b");

      // STEP=4: back-to-back, start held in DONE skips IDLE
      accept_op(2, 8'h11, 8'h22, 1'b0, 1'b0, "t6a");
      wait_done(2, 2, 8'h33, 1'b0, 1'b0, "t6a");
      a_i = 8'h00; b_i = 8'h01; cin_i = 1'b0; sub_i = 1'b1; start_v[2] = 1'b1;
      @(posedge clk); #1;
      chk(32'(busy_w[2]), 32'd1, "t6_b2b_busy");
      chk(32'(so_w[2]), 32'd0, "t6_b2b_SO_cleared");
      start_v[2] = 1'b0;
      a_i = 8'h55; b_i = 8'h66; sub_i = 1'b0;
      wait_done(2, 2, 8'hFF, 1'b0, 1'b0, "t6b");

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
